// File: rtl/ship_board_ctrl.sv
// Battleship board controller: ship placement, start gating, one-deep shot handshake.
// Clicks are edge-detected against 8'hFF idle; all outputs are registered.
module ship_board_ctrl #(
  parameter int MAX_CELLS = 20,
  parameter int BOARD_N   = 10
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [7:0]                     player_cor,
  input  logic [7:0]                     enemy_cor,
  input  logic                           start_btn,
  input  logic                           shot_ready,
  output logic [1:0]                     phase,
  output logic [BOARD_N*BOARD_N-1:0]     player_board,
  output logic [BOARD_N*BOARD_N-1:0]     shot_map,
  output logic [6:0]                     cells_placed,
  output logic                           shot_valid,
  output logic [7:0]                     shot_cor,
  output logic                           err
);

  localparam int NC = BOARD_N * BOARD_N;
  localparam int IW = $clog2(NC);
  localparam logic [3:0] BN   = 4'(BOARD_N);
  localparam logic [6:0] MAXC = 7'(MAX_CELLS);

  typedef enum logic [1:0] {
    PLACE    = 2'd0,
    SHOOT    = 2'd1,
    WAIT_ACK = 2'd2,
    BAD      = 2'd3
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [NC-1:0]   board_q, board_d;
  logic [NC-1:0]   shot_q, shot_d;
  logic [6:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [7:0]      cor_q, cor_d;
  logic            err_q, err_d;
  logic [7:0]      pp_q, pe_q;
  logic            ps_q;
  logic            live_q;

  logic            p_ev, e_ev, s_ev;
  logic            p_in, e_in;
  logic [IW-1:0]   p_idx, e_idx;

  function automatic logic [IW-1:0] idx_of(input logic [7:0] c);
    return IW'(int'(c[3:0]) * BOARD_N + int'(c[7:4]));
  endfunction

  // live_q masks the first cycle after reset so inputs held through reset
  // are absorbed into the edge registers instead of firing.
  assign p_ev = live_q && (player_cor != 8'hFF) && (pp_q == 8'hFF);
  assign e_ev = live_q && (enemy_cor != 8'hFF) && (pe_q == 8'hFF);
  assign s_ev = live_q && start_btn && !ps_q;

  assign p_in  = (player_cor[7:4] < BN) && (player_cor[3:0] < BN);
  assign e_in  = (enemy_cor[7:4] < BN) && (enemy_cor[3:0] < BN);
  assign p_idx = idx_of(player_cor);
  assign e_idx = idx_of(enemy_cor);

  always_comb begin
    phase_d = phase_q;
    board_d = board_q;
    shot_d  = shot_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    cor_d   = cor_q;
    err_d   = 1'b0;
    unique case (phase_q)
      PLACE: begin
        if (p_ev) begin
          if (!p_in) begin
            err_d = 1'b1;
          end else if (board_q[p_idx]) begin
            board_d[p_idx] = 1'b0;
            cnt_d = cnt_q - 7'd1;
          end else if (cnt_q < MAXC) begin
            board_d[p_idx] = 1'b1;
            cnt_d = cnt_q + 7'd1;
          end else begin
            err_d = 1'b1;
          end
        end
        // start check deliberately uses the pre-update count
        if (s_ev) begin
          if (cnt_q == MAXC) phase_d = SHOOT;
          else err_d = 1'b1;
        end
      end
      SHOOT: begin
        if (e_ev) begin
          if (e_in && !shot_q[e_idx]) begin
            shot_d[e_idx] = 1'b1;
            cor_d   = enemy_cor;
            valid_d = 1'b1;
            phase_d = WAIT_ACK;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      WAIT_ACK: begin
        if (shot_ready) begin
          valid_d = 1'b0;
          phase_d = SHOOT;
        end
      end
      BAD: begin
        valid_d = 1'b0;
        phase_d = PLACE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= PLACE;
      board_q <= '0;
      shot_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      cor_q   <= 8'hFF;
      err_q   <= 1'b0;
      pp_q    <= 8'hFF;
      pe_q    <= 8'hFF;
      ps_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      board_q <= board_d;
      shot_q  <= shot_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      cor_q   <= cor_d;
      err_q   <= err_d;
      pp_q    <= player_cor;
      pe_q    <= enemy_cor;
      ps_q    <= start_btn;
      live_q  <= 1'b1;
    end
  end

  assign phase        = phase_q;
  assign player_board = board_q;
  assign shot_map     = shot_q;
  assign cells_placed = cnt_q;
  assign shot_valid   = valid_q;
  assign shot_cor     = cor_q;
  assign err          = err_q;

endmodule

// File: tb/tb_ship_board_ctrl.sv
// Bench for ship_board_ctrl: directed scenarios with literal checks plus
// randomized traffic compared every cycle against a behavioural board model.
module tb_ship_board_ctrl;

  localparam int N    = 10;
  localparam int NC   = N * N;
  localparam int MAXC = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    player_cor = 8'hFF;
  logic [7:0]    enemy_cor  = 8'hFF;
  logic          start_btn  = 1'b0;
  logic          shot_ready = 1'b0;
  logic [1:0]    phase;
  logic [NC-1:0] player_board;
  logic [NC-1:0] shot_map;
  logic [6:0]    cells_placed;
  logic          shot_valid;
  logic [7:0]    shot_cor;
  logic          err;

  always #5 clk = ~clk;

  ship_board_ctrl #(.MAX_CELLS(MAXC), .BOARD_N(N)) dut (
    .clk          (clk),
    .rst          (rst),
    .player_cor   (player_cor),
    .enemy_cor    (enemy_cor),
    .start_btn    (start_btn),
    .shot_ready   (shot_ready),
    .phase        (phase),
    .player_board (player_board),
    .shot_map     (shot_map),
    .cells_placed (cells_placed),
    .shot_valid   (shot_valid),
    .shot_cor     (shot_cor),
    .err          (err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // behavioural model: game rules over plain arrays and integers
  int         m_phase = 0;
  bit         m_board[NC];
  bit         m_shot[NC];
  int         m_cnt = 0;
  bit         m_valid = 0;
  logic [7:0] m_cor = 8'hFF;
  bit         m_err = 0;
  logic [7:0] m_lastp = 8'hFF;
  logic [7:0] m_laste = 8'hFF;
  bit         m_lasts = 0;
  bit         m_fresh = 1;
  bit         m_started = 0;

  task automatic model_step();
    bit pclick, eclick, sclick;
    int x, y, cnt_before;
    pclick = !m_fresh && player_cor != 8'hFF && m_lastp == 8'hFF;
    eclick = !m_fresh && enemy_cor != 8'hFF && m_laste == 8'hFF;
    sclick = !m_fresh && start_btn && !m_lasts;
    m_err = 0;
    if (rst) begin
      m_phase = 0;
      for (int i = 0; i < NC; i++) begin
        m_board[i] = 0;
        m_shot[i] = 0;
      end
      m_cnt = 0; m_valid = 0; m_cor = 8'hFF;
      m_lastp = 8'hFF; m_laste = 8'hFF; m_lasts = 0;
      m_fresh = 1;
      return;
    end
    cnt_before = m_cnt;
    if (m_phase == 0) begin
      if (pclick) begin
        x = int'(player_cor[7:4]);
        y = int'(player_cor[3:0]);
        if (x >= N || y >= N) m_err = 1;
        else if (m_board[y*N+x]) begin
          m_board[y*N+x] = 0; m_cnt--;
        end else if (m_cnt < MAXC) begin
          m_board[y*N+x] = 1; m_cnt++;
        end else m_err = 1;
      end
      if (sclick) begin
        if (cnt_before == MAXC) m_phase = 1;
        else m_err = 1;
      end
    end else if (m_phase == 1) begin
      if (eclick) begin
        x = int'(enemy_cor[7:4]);
        y = int'(enemy_cor[3:0]);
        if (x >= N || y >= N || m_shot[y*N+x]) m_err = 1;
        else begin
          m_shot[y*N+x] = 1; m_cor = enemy_cor;
          m_valid = 1; m_phase = 2;
        end
      end
    end else if (m_phase == 2) begin
      if (shot_ready) begin
        m_valid = 0; m_phase = 1;
      end
    end else begin
      m_phase = 0;
    end
    m_lastp = player_cor;
    m_laste = enemy_cor;
    m_lasts = start_btn;
    m_fresh = 0;
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
    m_started = 1;
  end

  initial forever begin
    logic [NC-1:0] eb, es;
    @(negedge clk);
    if (m_started) begin
      for (int i = 0; i < NC; i++) begin
        eb[i] = m_board[i];
        es[i] = m_shot[i];
      end
      chk("m_phase", 128'(phase), 128'(m_phase[1:0]));
      chk("m_board", 128'(player_board), 128'(eb));
      chk("m_shots", 128'(shot_map), 128'(es));
      chk("m_cells", 128'(cells_placed), 128'(m_cnt[6:0]));
      chk("m_valid", 128'(shot_valid), 128'(m_valid));
      chk("m_cor", 128'(shot_cor), 128'(m_cor));
      chk("m_err", 128'(err), 128'(m_err));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic place(input logic [7:0] c);
    player_cor = c;
    tick();
    player_cor = 8'hFF;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic fill20();
    for (int i = 0; i < 20; i++) place({4'(i % 10), 4'(i / 10)});
  endtask

  task automatic rand_run(input int cycles, input bit allow_rst);
    int x;
    for (int k = 0; k < cycles; k++) begin
      rst = allow_rst && ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 0) player_cor = 8'hFF;
      else begin
        x = $urandom_range(0, 6);
        if (x == 6) x = 10;
        player_cor = {4'(x), 4'($urandom_range(0, 4))};
      end
      if ($urandom_range(0, 1) == 0) enemy_cor = 8'hFF;
      else enemy_cor = {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
      start_btn  = ($urandom_range(0, 3) == 0);
      shot_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    rst = 1'b0; player_cor = 8'hFF; enemy_cor = 8'hFF;
    start_btn = 1'b0; shot_ready = 1'b0;
    tick();
  endtask

  logic [NC-1:0] only54;

  initial begin
    only54 = '0;
    only54[54] = 1'b1;

    repeat (3) tick();
    chk("rst_phase", 128'(phase), 128'(2'd0));
    chk("rst_cells", 128'(cells_placed), 128'(7'd0));
    chk("rst_cor", 128'(shot_cor), 128'(8'hFF));
    chk("rst_valid", 128'(shot_valid), 128'(1'b0));
    rst = 1'b0;
    tick();

    player_cor = 8'h23; tick();
    chk("place_bit32", 128'(player_board[32]), 128'(1'b1));
    chk("place_cnt1", 128'(cells_placed), 128'(7'd1));
    player_cor = 8'hFF; tick();
    player_cor = 8'h23; tick();
    chk("remove_bit32", 128'(player_board[32]), 128'(1'b0));
    chk("remove_cnt0", 128'(cells_placed), 128'(7'd0));
    player_cor = 8'hFF; tick();

    do_reset();
    for (int i = 0; i < 5; i++) place({4'(i), 4'd0});
    start_btn = 1'b1; tick();
    chk("early_err", 128'(err), 128'(1'b1));
    chk("early_phase", 128'(phase), 128'(2'd0));
    start_btn = 1'b0; tick();

    do_reset();
    fill20();
    player_cor = 8'h99; tick();
    chk("full_err", 128'(err), 128'(1'b1));
    chk("full_cnt", 128'(cells_placed), 128'(7'd20));
    chk("full_bit99", 128'(player_board[99]), 128'(1'b0));
    player_cor = 8'hFF; tick();
    start_btn = 1'b1; tick();
    chk("start_phase", 128'(phase), 128'(2'd1));
    start_btn = 1'b0; tick();

    enemy_cor = 8'h45; tick();
    chk("shot_valid", 128'(shot_valid), 128'(1'b1));
    chk("shot_cor", 128'(shot_cor), 128'(8'h45));
    chk("shot_bit54", 128'(shot_map[54]), 128'(1'b1));
    chk("shot_phase", 128'(phase), 128'(2'd2));
    enemy_cor = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("shot_hold", 128'(shot_valid), 128'(1'b1));
    end
    shot_ready = 1'b1; tick();
    chk("ack_valid", 128'(shot_valid), 128'(1'b0));
    chk("ack_phase", 128'(phase), 128'(2'd1));
    shot_ready = 1'b0;

    enemy_cor = 8'h45; tick();
    chk("repeat_err", 128'(err), 128'(1'b1));
    chk("repeat_valid", 128'(shot_valid), 128'(1'b0));
    enemy_cor = 8'hFF; tick();
    enemy_cor = 8'hA0; tick();
    chk("oob_err", 128'(err), 128'(1'b1));
    chk("oob_phase", 128'(phase), 128'(2'd1));
    chk("oob_map", 128'(shot_map), 128'(only54));
    enemy_cor = 8'hFF; tick();

    enemy_cor = 8'h00; tick();
    enemy_cor = 8'hFF;
    chk("wa_valid", 128'(shot_valid), 128'(1'b1));
    player_cor = 8'h11;
    rst = 1'b1; tick();
    chk("rstwa_valid", 128'(shot_valid), 128'(1'b0));
    chk("rstwa_phase", 128'(phase), 128'(2'd0));
    chk("rstwa_cor", 128'(shot_cor), 128'(8'hFF));
    chk("rstwa_map", 128'(shot_map), 128'(0));
    tick();
    rst = 1'b0;
    repeat (3) tick();
    chk("held_board", 128'(player_board), 128'(0));
    chk("held_cnt", 128'(cells_placed), 128'(7'd0));
    player_cor = 8'hFF; tick();

    rand_run(1500, 1'b1);
    do_reset();
    fill20();
    start_btn = 1'b1; tick();
    start_btn = 1'b0; tick();
    rand_run(1500, 1'b0);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ship_board_ctrl.md
SHIP_BOARD_CTRL -- requirements
Module: ship_board_ctrl

Interface
REQ-001 SHALL have parameter MAX_CELLS, default 20, number of ship cells the player places before the game can start.
REQ-002 SHALL have parameter BOARD_N, default 10, board edge length in cells.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port player_cor  input  8  player-board click: [7:4] column x, [3:0] row y; 8'hFF = no click.
REQ-006 SHALL have port enemy_cor  input  8  enemy-board click, same format as player_cor.
REQ-007 SHALL have port start_btn  input  1  level, high while start button is pressed.
REQ-008 SHALL have port shot_ready  input  1  downstream accepts the shot on a cycle where shot_valid is also high.
REQ-009 SHALL have port phase  output  2  2'd0 PLACE, 2'd1 SHOOT, 2'd2 WAIT_ACK.
REQ-010 SHALL have port player_board  output  100  ship map, bit index y*BOARD_N+x, 1 = ship cell.
REQ-011 SHALL have port shot_map  output  100  cells already fired at, same indexing as player_board.
REQ-012 SHALL have port cells_placed  output  7  count of set bits in player_board.
REQ-013 SHALL have port shot_valid  output  1  a shot is pending.
REQ-014 SHALL have port shot_cor  output  8  coordinate of the pending shot; stable while shot_valid is high.
REQ-015 SHALL have port err  output  1  one-cycle pulse on a rejected action.

Function
REQ-016 SHALL register player_cor, enemy_cor and start_btn each cycle; click event = current != 8'hFF AND registered previous == 8'hFF; start event = start_btn high AND previous low.
REQ-017 SHALL treat a held button (same coordinate on consecutive cycles) as a single event; a changed coordinate without an intervening 8'hFF is not a new event.
REQ-018 SHALL treat a coordinate with x >= BOARD_N or y >= BOARD_N as out of range: no state change, err pulses one cycle after the event.
REQ-019 PLACE, player click event, in range: a cell at 1 is cleared and the count decrements; a cell at 0 is set and the count increments if cells_placed < MAX_CELLS.
REQ-020 PLACE, player click event on an empty cell when cells_placed == MAX_CELLS: board unchanged, err pulses.
REQ-021 Board and count updates SHALL be visible on the cycle after the event cycle (one-cycle latency).
REQ-022 PLACE -> SHOOT on a start event when cells_placed == MAX_CELLS; a start event with a lower count SHALL pulse err and stay in PLACE.
REQ-023 PLACE SHALL ignore enemy click events; SHOOT and WAIT_ACK SHALL ignore player click events and start events, and player_board SHALL stay frozen.
REQ-024 SHOOT, enemy click event, in range, shot_map bit 0: latch shot_cor, set the shot_map bit, assert shot_valid, go to WAIT_ACK, all visible on the next cycle.
REQ-025 SHOOT, enemy click event on a cell whose shot_map bit is already 1: err pulses, stay in SHOOT, shot_valid stays 0.
REQ-026 WAIT_ACK: hold shot_valid and shot_cor until a cycle with shot_ready high; the next cycle shot_valid = 0 and phase = SHOOT.
REQ-027 WAIT_ACK SHALL ignore enemy click events; there SHALL be no shot queue.
REQ-028 shot_ready high while shot_valid is low SHALL have no effect.
REQ-029 If a player click event and a start event occur in the same PLACE cycle, the board update SHALL apply and the start check SHALL use the pre-update count.
REQ-030 The unused phase encoding 2'd3 SHALL return to PLACE on the next cycle.
REQ-031 err SHALL be registered, high for exactly one cycle per rejected event, with no other pulse sources.

Reset
REQ-032 On rst high at a clock edge: phase = PLACE, player_board = 0, shot_map = 0, cells_placed = 0, shot_valid = 0, shot_cor = 8'hFF, err = 0.
REQ-033 On rst, edge-detect registers SHALL load 8'hFF (coordinates) and 0 (start_btn), so an input held during reset creates no event after release.
REQ-034 rst mid-operation, including in WAIT_ACK with shot_valid high, SHALL drop any pending shot in the same cycle without waiting for shot_ready.

Verification
REQ-035 Place/remove: player_cor 8'h23 one cycle, then 8'hFF -> player_board bit 32 = 1, cells_placed = 1; repeat -> bit 32 = 0, count = 0.
REQ-036 Full board: 20 distinct clicks, then click 8'h99 -> err pulse, cells_placed = 20, bit 99 = 0; start_btn rise -> phase = 1.
REQ-037 Early start: 5 cells placed, start_btn rise -> err pulse, phase stays 0.
REQ-038 Shot handshake: in SHOOT, enemy_cor 8'h45 -> shot_valid = 1, shot_cor = 8'h45, shot_map bit 54 = 1; shot_ready low 3 cycles then high -> shot_valid clears, phase = 1.
REQ-039 Repeat/out of range: enemy_cor 8'h45 again -> err, shot_valid = 0; enemy_cor 8'hA0 -> err, no change.
REQ-040 Reset in WAIT_ACK with player_cor held at 8'h11 through reset -> all outputs at reset values, no placement after rst release.
